// File: rtl/univ_shift_reg_if.sv
// Control, data and status bundle for the universal shift register.
// The master side drives mode/data; the slave side owns Q, cnt and done.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             en;
    logic [1:0]       mode;
    logic             rot;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             sout_r;
    logic             sout_l;
    logic [CW-1:0]    cnt;
    logic             done;

    modport master (
        output en, mode, rot, sin_r, sin_l, D,
        input  Q, sout_r, sout_l, cnt, done
    );

    modport slave (
        input  en, mode, rot, sin_r, sin_l, D,
        output Q, sout_r, sout_l, cnt, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / load,
// optional rotate, serial taps and a shift counter pulsing done every WIDTH shifts.
module univ_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    univ_shift_reg_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] shl;
    logic             wrap;

    always_comb begin
        shr  = {bus.rot ? bus.Q[0] : bus.sin_r, bus.Q[WIDTH-1:1]};
        shl  = {bus.Q[WIDTH-2:0], bus.rot ? bus.Q[WIDTH-1] : bus.sin_l};
        wrap = (bus.cnt == LAST);
    end

    assign bus.sout_r = bus.Q[0];
    assign bus.sout_l = bus.Q[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Q    <= RST_VAL;
            bus.cnt  <= '0;
            bus.done <= 1'b0;
        end else if (!bus.en) begin
            bus.done <= 1'b0;
        end else begin
            case (bus.mode)
                2'b01, 2'b10: begin
                    bus.Q    <= (bus.mode == 2'b01) ? shr : shl;
                    // Wrap on the WIDTH-th shift so done lines up with it.
                    bus.cnt  <= wrap ? '0 : bus.cnt + CW'(1);
                    bus.done <= wrap;
                end
                2'b11: begin
                    bus.Q    <= bus.D;
                    bus.cnt  <= '0;
                    bus.done <= 1'b0;
                end
                default: begin
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: reference model feeds a scoreboard
// queue at drive time; results are popped and checked after each edge.
module tb_univ_shift_reg;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(8)) bus ();

    univ_shift_reg #(
        .WIDTH  (8),
        .RST_VAL(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] c;
        logic       d;
    } exp_t;

    exp_t  sb[$];
    string tq[$];

    logic [7:0] mq = 8'h00;
    int         mc = 0;
    logic       md = 1'b0;
    int         vecs = 0;
    int         fails = 0;
    bit         saw_done = 1'b0;

    task automatic drive(bit rs, bit e, logic [1:0] m, bit r, bit sr,
                         bit sl, logic [7:0] d, string tag);
        rst       = rs;
        bus.en    = e;
        bus.mode  = m;
        bus.rot   = r;
        bus.sin_r = sr;
        bus.sin_l = sl;
        bus.D     = d;
        if (rs) begin
            mq = 8'h00;
            mc = 0;
            md = 1'b0;
        end else if (!e || m == 2'd0) begin
            md = 1'b0;
        end else if (m == 2'd3) begin
            mq = d;
            mc = 0;
            md = 1'b0;
        end else begin
            if (m == 2'd1) mq = {(r ? mq[0] : sr), mq[7:1]};
            else           mq = {mq[6:0], (r ? mq[7] : sl)};
            mc = mc + 1;
            md = (mc == 8);
            if (mc == 8) mc = 0;
        end
        sb.push_back('{mq, 4'(mc), md});
        tq.push_back(tag);
    endtask

    task automatic check();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_empty: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        t = tq.pop_front();
        vecs++;
        if (bus.done === 1'b1) saw_done = 1'b1;
        assert (bus.Q === e.q && bus.cnt === e.c && bus.done === e.d &&
                bus.sout_r === e.q[0] && bus.sout_l === e.q[7])
        else begin
            fails++;
            $error("FAIL %s: got Q=%h cnt=%0d done=%b sr=%b sl=%b, want Q=%h cnt=%0d done=%b",
                   t, bus.Q, bus.cnt, bus.done, bus.sout_r, bus.sout_l,
                   e.q, e.c, e.d);
        end
    endtask

    task automatic step(bit rs, bit e, logic [1:0] m, bit r, bit sr,
                        bit sl, logic [7:0] d, string tag);
        @(negedge clk);
        drive(rs, e, m, r, sr, sl, d, tag);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic kchk(string tag, logic [7:0] got, logic [7:0] exp);
        vecs++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.en    = 1'b0;
        bus.mode  = 2'd0;
        bus.rot   = 1'b0;
        bus.sin_r = 1'b0;
        bus.sin_l = 1'b0;
        bus.D     = 8'h00;

        // reset wins over a requested load
        step(1, 1, 2'd3, 0, 0, 0, 8'hFF, "rst_load");
        kchk("rst_q", bus.Q, 8'h00);
        kchk("rst_sout_r", 8'(bus.sout_r), 8'h00);

        // load then hold with en=0
        step(0, 1, 2'd3, 0, 0, 0, 8'hA5, "load_a5");
        kchk("load_q", bus.Q, 8'hA5);
        repeat (3) step(0, 0, 2'd3, 0, 0, 0, 8'h3C, "hold_en0");
        kchk("hold_q", bus.Q, 8'hA5);
        kchk("hold_cnt", 8'(bus.cnt), 8'd0);

        // serial shift right
        kchk("pre_sout_r", 8'(bus.sout_r), 8'h01);
        step(0, 1, 2'd1, 0, 1, 0, 8'h00, "shr_sin1");
        kchk("shr_q", bus.Q, 8'hD2);
        kchk("shr_cnt", 8'(bus.cnt), 8'd1);
        kchk("post_sout_r", 8'(bus.sout_r), 8'h00);

        // rotate left a full word
        step(0, 1, 2'd3, 0, 0, 0, 8'h81, "load_81");
        step(0, 1, 2'd2, 1, 0, 0, 8'h00, "rotl_1");
        kchk("rotl_first", bus.Q, 8'h03);
        kchk("rotl_nodone", 8'(bus.done), 8'h00);
        repeat (6) step(0, 1, 2'd2, 1, 0, 0, 8'h00, "rotl_mid");
        step(0, 1, 2'd2, 1, 0, 0, 8'h00, "rotl_8");
        kchk("rotl_q", bus.Q, 8'h81);
        kchk("rotl_done", 8'(bus.done), 8'h01);
        kchk("rotl_cnt", 8'(bus.cnt), 8'd0);
        step(0, 1, 2'd0, 0, 0, 0, 8'h00, "after_done");
        kchk("done_drop", 8'(bus.done), 8'h00);

        // reset and load discard partial counts
        saw_done = 1'b0;
        repeat (3) step(0, 1, 2'd1, 0, 1, 0, 8'h00, "part_shr");
        kchk("part_cnt", 8'(bus.cnt), 8'd3);
        step(1, 1, 2'd1, 0, 0, 0, 8'h00, "mid_rst");
        kchk("mid_rst_q", bus.Q, 8'h00);
        kchk("mid_rst_cnt", 8'(bus.cnt), 8'd0);
        repeat (7) step(0, 1, 2'd2, 0, 1, 0, 8'h00, "seven_shl");
        kchk("seven_cnt", 8'(bus.cnt), 8'd7);
        step(0, 1, 2'd3, 0, 0, 0, 8'h5A, "load_at_wrap");
        kchk("load_wrap_cnt", 8'(bus.cnt), 8'd0);
        kchk("never_done", 8'(saw_done), 8'h00);

        // continuous mixed shifting, done every 8 shifts
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, ((i % 3) == 0) ? 2'd1 : 2'd2, 1'($urandom_range(1)),
                 1'($urandom_range(1)), 1'($urandom_range(1)), 8'h00, "mixed");
            if (i == 7 || i == 15) kchk("mixed_done", 8'(bus.done), 8'h01);
        end
        step(0, 0, 2'd1, 0, 1, 1, 8'h00, "en0_shift");
        kchk("en0_cnt", 8'(bus.cnt), 8'd4);

        // inputs wiggled between edges: only edge-time values count
        for (int k = 0; k < 3; k++) begin
            #2;
            bus.en    = 1'b1;
            bus.mode  = 2'd3;
            bus.D     = 8'(8'h11 * (k + 1));
            bus.sin_r = ~bus.sin_r;
            #5;
            case (k)
                0: drive(0, 1, 2'd3, 0, 0, 0, 8'hC3, "midcyc_load");
                1: drive(0, 1, 2'd1, 0, 0, 0, 8'h77, "midcyc_shr");
                default: drive(0, 0, 2'd3, 0, 1, 0, 8'hEE, "midcyc_hold");
            endcase
            @(posedge clk);
            #1;
            check();
        end
        kchk("midcyc_q", bus.Q, 8'h61);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
